// File: rtl/mem_wb_pkg.sv
// Shared definitions for the pipeline stage registers of the 16-bit core.
package mem_wb_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned RADDR_W = 3;

  // MEM -> WB payload, control bits first
  typedef struct packed {
    logic               RegWrite;
    logic               RegStore;
    logic [DATA_W-1:0]  PCP2;
    logic [DATA_W-1:0]  ALUResult;
    logic [DATA_W-1:0]  StoreMem;
    logic [RADDR_W-1:0] Rd;
  } mem_wb_t;

  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

  // Bubble value: no register-file write, all data fields cleared
  function automatic mem_wb_t mem_wb_bubble();
    mem_wb_t b;
    b = '0;
    return b;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_reg.sv
// Generic pipeline flop: synchronous reset, clear and load enable.
// Priority: rst > clr > en > hold. Reset and clear both load zero.
module pipe_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture / clear / hold register
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register. Captures MEM-stage control and data on each
// enabled edge and presents them, registered, to write-back.
// Optional feature macro: MEM_WB_FLUSH_EN adds a Flush input that turns
// the captured slot into a bubble while keeping the data fields.
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W  = mem_wb_pkg::DATA_W,
  parameter int unsigned RADDR_W = mem_wb_pkg::RADDR_W
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               RegWrite,
`ifdef MEM_WB_FLUSH_EN
  input  logic               Flush,
`endif
  input  logic               IRegWrite,
  input  logic               IRegStore,
  input  logic [DATA_W-1:0]  IPCP2,
  input  logic [DATA_W-1:0]  IALUResult,
  input  logic [DATA_W-1:0]  IStoreMem,
  input  logic [RADDR_W-1:0] IRd,
  output logic               ORegWrite,
  output logic               ORegStore,
  output logic [DATA_W-1:0]  OPCP2,
  output logic [DATA_W-1:0]  OALUResult,
  output logic [DATA_W-1:0]  OStoreMem,
  output logic [RADDR_W-1:0] ORd
);

  localparam int unsigned CTRL_W = 2;
  localparam int unsigned DBUS_W = 3 * DATA_W + RADDR_W;

  logic              flush;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DBUS_W-1:0] data_d, data_q;
  logic              data_en;

`ifdef MEM_WB_FLUSH_EN
  assign flush = Flush;
`else
  assign flush = 1'b0;
`endif

  // A flushed slot keeps its data, so the data flops must not load either
  assign data_en = RegWrite & ~flush;

  assign ctrl_d = {IRegWrite, IRegStore};
  assign data_d = {IPCP2, IALUResult, IStoreMem, IRd};

  pipe_reg #(.WIDTH(CTRL_W)) u_ctrl (
    .clk (CLK),
    .rst (Reset),
    .en  (RegWrite),
    .clr (flush),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  pipe_reg #(.WIDTH(DBUS_W)) u_data (
    .clk (CLK),
    .rst (Reset),
    .en  (data_en),
    .clr (1'b0),
    .d   (data_d),
    .q   (data_q)
  );

  assign {ORegWrite, ORegStore}             = ctrl_q;
  assign {OPCP2, OALUResult, OStoreMem, ORd} = data_q;

endmodule

// File: tb/tb_mem_wb.sv
// Randomised bench for mem_wb with a behavioural model and directed anchors.
module tb_mem_wb;
  import mem_wb_pkg::*;

  logic               CLK = 1'b0;
  logic               Reset, RegWrite, IRegWrite, IRegStore;
  logic [DATA_W-1:0]  IPCP2, IALUResult, IStoreMem;
  logic [RADDR_W-1:0] IRd;
  logic               ORegWrite, ORegStore;
  logic [DATA_W-1:0]  OPCP2, OALUResult, OStoreMem;
  logic [RADDR_W-1:0] ORd;
`ifdef MEM_WB_FLUSH_EN
  logic               Flush = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  mem_wb dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .RegWrite   (RegWrite),
`ifdef MEM_WB_FLUSH_EN
    .Flush      (Flush),
`endif
    .IRegWrite  (IRegWrite),
    .IRegStore  (IRegStore),
    .IPCP2      (IPCP2),
    .IALUResult (IALUResult),
    .IStoreMem  (IStoreMem),
    .IRd        (IRd),
    .ORegWrite  (ORegWrite),
    .ORegStore  (ORegStore),
    .OPCP2      (OPCP2),
    .OALUResult (OALUResult),
    .OStoreMem  (OStoreMem),
    .ORd        (ORd)
  );

  // Behavioural model: what the stage register must hold after each edge
  mem_wb_t exp_s;
  bit      model_ok = 0;

  always @(posedge CLK) begin
    if (Reset === 1'b1) begin
      exp_s    = '0;
      model_ok = 1;
    end
`ifdef MEM_WB_FLUSH_EN
    else if (Flush) begin
      exp_s.RegWrite = 1'b0;
      exp_s.RegStore = 1'b0;
    end
`endif
    else if (RegWrite) begin
      exp_s.RegWrite  = IRegWrite;
      exp_s.RegStore  = IRegStore;
      exp_s.PCP2      = IPCP2;
      exp_s.ALUResult = IALUResult;
      exp_s.StoreMem  = IStoreMem;
      exp_s.Rd        = IRd;
    end
  end

  function automatic mem_wb_t dut_s();
    mem_wb_t a;
    a.RegWrite  = ORegWrite;
    a.RegStore  = ORegStore;
    a.PCP2      = OPCP2;
    a.ALUResult = OALUResult;
    a.StoreMem  = OStoreMem;
    a.Rd        = ORd;
    return a;
  endfunction

  // Every-cycle compare against the model, away from the active edge
  always @(negedge CLK) begin
    if (model_ok) begin
      vectors++;
      if (dut_s() !== exp_s) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, dut_s(), exp_s);
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp_v);
    end
  endtask

  task automatic check_all(input string nm, input logic rw, input logic rs,
                           input logic [15:0] pc, input logic [15:0] alu,
                           input logic [15:0] mem, input logic [2:0] rd);
    check({nm, "_rw"},  64'(ORegWrite),  64'(rw));
    check({nm, "_rs"},  64'(ORegStore),  64'(rs));
    check({nm, "_pc"},  64'(OPCP2),      64'(pc));
    check({nm, "_alu"}, 64'(OALUResult), 64'(alu));
    check({nm, "_mem"}, 64'(OStoreMem),  64'(mem));
    check({nm, "_rd"},  64'(ORd),        64'(rd));
  endtask

  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic rw, input logic rs, input logic [15:0] pc,
                       input logic [15:0] alu, input logic [15:0] mem, input logic [2:0] rd);
    IRegWrite  = rw;
    IRegStore  = rs;
    IPCP2      = pc;
    IALUResult = alu;
    IStoreMem  = mem;
    IRd        = rd;
  endtask

  initial begin
    Reset    = 1'b1;
    RegWrite = 1'b1;
    drive(1'b1, 1'b0, 16'h1234, 16'h5678, 16'h9ABC, 3'd3);

    // Reset wins over RegWrite
    edge1();
    check_all("reset", 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);

    // First capture after reset release
    Reset = 1'b0;
    edge1();
    check_all("load", 1'b1, 1'b0, 16'h1234, 16'h5678, 16'h9ABC, 3'd3);

    // Stall holds for three edges despite changed inputs
    RegWrite = 1'b0;
    drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd7);
    repeat (3) edge1();
    check_all("hold", 1'b1, 1'b0, 16'h1234, 16'h5678, 16'h9ABC, 3'd3);

    RegWrite = 1'b1;
    edge1();
    check_all("reload", 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd7);

    // Back-to-back loads, one cycle latency each
    for (int i = 1; i <= 3; i++) begin
      IALUResult = 16'(i);
      edge1();
      check("b2b_alu", 64'(OALUResult), 64'(i));
    end

    // Reset pulse mid-operation discards inputs, next edge reloads
    drive(1'b1, 1'b1, 16'hA5A5, 16'h0F0F, 16'h3C3C, 3'd5);
    Reset = 1'b1;
    edge1();
    check_all("rst_pulse", 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
    Reset = 1'b0;
    edge1();
    check_all("after_rst", 1'b1, 1'b1, 16'hA5A5, 16'h0F0F, 16'h3C3C, 3'd5);

    // Reset glitch between edges has no effect
    drive(1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 3'd1);
    RegWrite = 1'b0;
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    edge1();
    check("glitch_alu", 64'(OALUResult), 64'h0F0F);
    check("glitch_rw",  64'(ORegWrite),  64'h1);

`ifdef MEM_WB_FLUSH_EN
    // Flush makes a bubble but keeps the data fields
    RegWrite = 1'b1;
    Flush    = 1'b1;
    drive(1'b1, 1'b1, 16'h4444, 16'h5555, 16'h6666, 3'd2);
    edge1();
    check_all("flush", 1'b0, 1'b0, 16'hA5A5, 16'h0F0F, 16'h3C3C, 3'd5);
    Flush = 1'b0;
`endif

    // Random traffic checked by the model every cycle
    for (int n = 0; n < 600; n++) begin
      Reset    = ($urandom_range(31) == 0);
      RegWrite = ($urandom_range(1) == 1);
`ifdef MEM_WB_FLUSH_EN
      Flush    = ($urandom_range(7) == 0);
`endif
      drive(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 3'($urandom));
      edge1();
    end

    Reset    = 1'b0;
    RegWrite = 1'b0;
    edge1();
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb.md
# mem_wb

Pipeline register between the memory (MEM) and write-back (WB) stages of the 16-bit pipelined core. Each enabled clock edge captures the MEM-stage control bits, the PC+2 link value, the ALU result, the memory load data and the destination register index. It presents them, registered, to the write-back mux and the register file. It has one load-enable (stall) control and synchronous reset to an all-zero bubble.

## Interface
Parameters:
- DATA_W, 16, width of the PC+2, ALU-result and memory-data fields
- RADDR_W, 3, width of the destination register index

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- RegWrite  in  1  pipeline-register load enable: 1 = capture inputs, 0 = hold (stall)
- IRegWrite  in  1  MEM-stage register-file write enable
- IRegStore  in  1  MEM-stage write-back source select (1 = memory data)
- IPCP2  in  DATA_W  PC+2 of the instruction (link value)
- IALUResult  in  DATA_W  ALU result
- IStoreMem  in  DATA_W  data read from data memory
- IRd  in  RADDR_W  destination register index
- ORegWrite, ORegStore  out  1  registered copies of IRegWrite, IRegStore
- OPCP2, OALUResult, OStoreMem  out  DATA_W  registered copies of the corresponding inputs
- ORd  out  RADDR_W  registered copy of IRd
- Flush  in  1  present only with MEM_WB_FLUSH_EN (see Configuration)

## Operation
- Per rising CLK, the first matching rule applies:
  1. Reset=1: all outputs load 0.
  2. Flush=1 (only if configured): ORegWrite and ORegStore load 0; data fields hold.
  3. RegWrite=1: every output loads its corresponding I* input.
  4. Otherwise: all outputs hold.
- No transformation of any field. Widths match exactly; no extension or truncation.
- All-zero state is a bubble: ORegWrite=0 suppresses the register-file write.

## Timing
- Latency exactly 1 cycle, input sampled at edge N, visible after edge N.
- Outputs are driven only by flops. There is no combinational path from any input to any output.
- Reset value of every output is 0. Outputs are unknown until the first edge with Reset=1.
- Reset is sampled only at CLK edges. Asserting it between edges has no effect until the next edge.
- Reset mid-operation (RegWrite=1, non-zero inputs) gives zeros after that edge; captured data is discarded.
- Reset and RegWrite both high: reset wins.
- Reset deasserted with RegWrite=1: the first capture happens on the next edge.
- RegWrite=0 for many cycles: values are held indefinitely.

## Configuration
- MEM_WB_FLUSH_EN defined: adds the Flush input with the priority above. A flushed slot becomes a bubble without losing the data fields.
- Undefined: no Flush port. Behaviour is rules 1, 3 and 4 only.

## Structure
- Shared package: DATA_W=16, RADDR_W=3, and a packed struct mem_wb_t bundling {RegWrite, RegStore, PCP2, ALUResult, StoreMem, Rd}. The package is reused by the neighbouring stage registers.
- One sub-module: pipe_reg, a generic WIDTH-parameterised flop with synchronous reset, enable and clear. It is instantiated once for the control bits and once for the data fields.

## Test plan
- Reset=1, RegWrite=1, IRegWrite=1, IRegStore=0, IPCP2=0x1234, IALUResult=0x5678, IStoreMem=0x9ABC, IRd=3; one edge -> all outputs 0.
- Same inputs, Reset=0; one edge -> ORegWrite=1, ORegStore=0, OPCP2=0x1234, OALUResult=0x5678, OStoreMem=0x9ABC, ORd=3.
- After the load, RegWrite=0 and inputs changed to 0xFFFF/7/IRegStore=1 for 3 edges -> outputs unchanged (0x1234, 0x5678, 0x9ABC, 3). Then RegWrite=1 for one edge -> new values appear.
- Back-to-back loads 0x0001, 0x0002, 0x0003 on consecutive edges, RegWrite=1 -> OALUResult follows each value one cycle later.
- Reset pulsed high for one edge while RegWrite=1 and inputs non-zero -> zeros after that edge. The next edge with Reset=0 reloads the inputs.
- With MEM_WB_FLUSH_EN: Flush=1, RegWrite=1, IRegWrite=1 -> ORegWrite=0 and ORegStore=0, with OALUResult keeping its prior value.
